// File: rtl/dbf_fine_apod_pkg.sv
// rtl/dbf_fine_apod_pkg.sv - shared widths and FSM encodings for the fine-delay/apodisation stage
package dbf_fine_apod_pkg;

    localparam int DEF_INPUT_WD = 14;
    localparam int DEF_FRAC_WD  = 4;
    localparam int DEF_APO_WD   = 16;
    localparam int DEF_ADDR_WD  = 10;
    localparam int DEF_OUT_WD   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dbf_fine_lut.sv
// rtl/dbf_fine_lut.sv - simple dual-port fine-delay fraction RAM, registered read port
module dbf_fine_lut #(
    parameter int ADDR_WD = 10,
    parameter int FRAC_WD = 4
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [ADDR_WD-1:0] wr_addr_i,
    input  logic [FRAC_WD-1:0] wr_data_i,
    input  logic [ADDR_WD-1:0] rd_addr_i,
    output logic [FRAC_WD-1:0] rd_data_o
);

    logic [FRAC_WD-1:0] mem_q [2**ADDR_WD];

    // Plain RAM: no reset so it maps onto block memory.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/dbf_fine_apod.sv
// rtl/dbf_fine_apod.sv - per-channel linear-interpolation fine delay and apodisation weight
// Optional DBF_FINE_ROUND_EN: round half toward +inf in the interpolation shift instead of floor.
module dbf_fine_apod
    import dbf_fine_apod_pkg::*;
#(
    parameter int INPUT_WD = DEF_INPUT_WD,
    parameter int FRAC_WD  = DEF_FRAC_WD,
    parameter int APO_WD   = DEF_APO_WD,
    parameter int ADDR_WD  = DEF_ADDR_WD,
    parameter int OUT_WD   = DEF_OUT_WD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [INPUT_WD-1:0] din,
    input  logic                din_valid,
    input  logic [APO_WD-1:0]   apo_din,
    input  logic [ADDR_WD-1:0]  lut_addr,
    input  logic                lut_we,
    input  logic [FRAC_WD-1:0]  lut_din,
    output logic [OUT_WD-1:0]   dout,
    output logic                dout_valid,
    output logic                lut_wr_err
);

    localparam int Y_WD    = INPUT_WD + 1;
    localparam int PROD_WD = INPUT_WD + FRAC_WD + 2;

    state_e                     state_q, state_d;
    logic [ADDR_WD-1:0]         cnt_q, cnt_d;
    logic                       run_ok, accept;
    logic                       lut_wr_en, wr_err_d, wr_err_q;
    logic [FRAC_WD-1:0]         f_rd;

    logic signed [INPUT_WD-1:0] x_prev_q;
    logic signed [INPUT_WD-1:0] x1_q, x0_s1_q, x0_s2_q, x0_s3_q;
    logic signed [APO_WD-1:0]   apo1_q, apo2_q, apo3_q, apo4_q;
    logic                       v1_q, v2_q, v3_q, v4_q;
    logic [FRAC_WD-1:0]         f2_q;

    logic signed [Y_WD-1:0]     diff_d, diff_q;
    logic signed [PROD_WD-1:0]  prod_d, prod_q, prod_adj;
    logic signed [Y_WD-1:0]     y_d, y_q;
    logic signed [OUT_WD-1:0]   mul_d, dout_q;
    logic                       dout_valid_q;

`ifdef DBF_FINE_ROUND_EN
    localparam logic signed [PROD_WD-1:0] ROUND_HALF = PROD_WD'(1 << (FRAC_WD - 1));
`endif

    // Samples are only taken once RUN is established and start is still held.
    assign run_ok    = (state_q == RUN) && start;
    assign accept    = run_ok && din_valid;
    assign state_d   = start ? RUN : IDLE;
    assign lut_wr_en = lut_we && (state_q == IDLE) && !start;
    assign wr_err_d  = lut_we && !lut_wr_en;
    assign cnt_d     = (cnt_q == {ADDR_WD{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    dbf_fine_lut #(
        .ADDR_WD (ADDR_WD),
        .FRAC_WD (FRAC_WD)
    ) u_lut (
        .clk_i     (clk),
        .wr_en_i   (lut_wr_en),
        .wr_addr_i (lut_addr),
        .wr_data_i (lut_din),
        .rd_addr_i (cnt_q),
        .rd_data_o (f_rd)
    );

    always_comb begin
        diff_d = $signed({x1_q[INPUT_WD-1], x1_q}) - $signed({x0_s1_q[INPUT_WD-1], x0_s1_q});
        prod_d = PROD_WD'(diff_q) * PROD_WD'($signed({1'b0, f2_q}));
`ifdef DBF_FINE_ROUND_EN
        prod_adj = prod_q + ROUND_HALF;
`else
        prod_adj = prod_q;
`endif
        // f < 2^FRAC_WD keeps the interpolated value between x0 and x1, so truncation is safe.
        y_d   = Y_WD'(PROD_WD'(x0_s3_q) + (prod_adj >>> FRAC_WD));
        mul_d = OUT_WD'(y_q) * OUT_WD'(apo4_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_err_q     <= 1'b0;
            cnt_q        <= '0;
            x_prev_q     <= '0;
            x1_q         <= '0;
            x0_s1_q      <= '0;
            x0_s2_q      <= '0;
            x0_s3_q      <= '0;
            apo1_q       <= '0;
            apo2_q       <= '0;
            apo3_q       <= '0;
            apo4_q       <= '0;
            f2_q         <= '0;
            diff_q       <= '0;
            prod_q       <= '0;
            y_q          <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            v4_q         <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_err_q <= wr_err_d;
            if (!run_ok) begin
                // Idle or start just dropped: flush in-flight samples.
                cnt_q        <= '0;
                x_prev_q     <= '0;
                v1_q         <= 1'b0;
                v2_q         <= 1'b0;
                v3_q         <= 1'b0;
                v4_q         <= 1'b0;
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                v1_q         <= accept;
                v2_q         <= v1_q;
                v3_q         <= v2_q;
                v4_q         <= v3_q;
                dout_valid_q <= v4_q;
                if (accept) begin
                    x1_q     <= $signed(din);
                    x0_s1_q  <= x_prev_q;
                    apo1_q   <= $signed(apo_din);
                    x_prev_q <= $signed(din);
                    cnt_q    <= cnt_d;
                end
                if (v1_q) begin
                    diff_q  <= diff_d;
                    f2_q    <= f_rd;
                    x0_s2_q <= x0_s1_q;
                    apo2_q  <= apo1_q;
                end
                if (v2_q) begin
                    prod_q  <= prod_d;
                    x0_s3_q <= x0_s2_q;
                    apo3_q  <= apo2_q;
                end
                if (v3_q) begin
                    y_q    <= y_d;
                    apo4_q <= apo3_q;
                end
                if (v4_q) begin
                    dout_q <= mul_d;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign lut_wr_err = wr_err_q;

endmodule

// File: tb/tb_dbf_fine_apod.sv
// tb/tb_dbf_fine_apod.sv - directed self-checking bench for dbf_fine_apod (ADDR_WD=3 instance)
module tb_dbf_fine_apod;

    localparam int INPUT_WD = 14;
    localparam int FRAC_WD  = 4;
    localparam int APO_WD   = 16;
    localparam int ADDR_WD  = 3;
    localparam int OUT_WD   = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [INPUT_WD-1:0] din;
    logic                din_valid;
    logic [APO_WD-1:0]   apo_din;
    logic [ADDR_WD-1:0]  lut_addr;
    logic                lut_we;
    logic [FRAC_WD-1:0]  lut_din;
    logic [OUT_WD-1:0]   dout;
    logic                dout_valid;
    logic                lut_wr_err;

    int checks   = 0;
    int failures = 0;
    int din_v [16];
    int exp_v [16];

    dbf_fine_apod #(
        .INPUT_WD (INPUT_WD),
        .FRAC_WD  (FRAC_WD),
        .APO_WD   (APO_WD),
        .ADDR_WD  (ADDR_WD),
        .OUT_WD   (OUT_WD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .apo_din    (apo_din),
        .lut_addr   (lut_addr),
        .lut_we     (lut_we),
        .lut_din    (lut_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .lut_wr_err (lut_wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input int addr, input int val);
        lut_addr = addr[ADDR_WD-1:0];
        lut_din  = val[FRAC_WD-1:0];
        lut_we   = 1'b1;
        tick();
        lut_we   = 1'b0;
    endtask

    task automatic lut_fill(input int val);
        for (int k = 0; k < 2**ADDR_WD; k++) lut_write(k, val);
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
    endtask

    task automatic end_run();
        start = 1'b0;
        tick();
        tick();
    endtask

    // Drive n back-to-back samples; output k must appear after the 5th edge counting its sampling edge.
    task automatic run_check(input string tag, input int n, input int apo);
        int  v;
        logic exp_valid;
        apo_din = apo[APO_WD-1:0];
        for (int t = 0; t < n + 8; t++) begin
            if (t < n) begin
                v         = din_v[t];
                din       = v[INPUT_WD-1:0];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            tick();
            exp_valid = (t >= 4) && (t - 4 < n);
            check({tag, "_vld"}, dout_valid, exp_valid);
            if (dout_valid && exp_valid) check({tag, "_dout"}, $signed(dout), exp_v[t-4]);
        end
        check({tag, "_hold"}, $signed(dout), exp_v[n-1]);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        apo_din   = '0;
        lut_addr  = '0;
        lut_we    = 1'b0;
        lut_din   = '0;
        tick();
        tick();
        check("rst_dout", dout, 0);
        check("rst_vld", dout_valid, 0);
        check("rst_err", lut_wr_err, 0);
        rst_n = 1'b1;
        tick();

        // f=0 selects x0, the previous sample
        lut_fill(0);
        begin_run();
        din_v[0] = 0;   din_v[1] = 100; din_v[2] = 200;
        exp_v[0] = 0;   exp_v[1] = 0;   exp_v[2] = 100;
        run_check("f0", 3, 1);
        end_run();

        // f=8 midpoint, apo=2, first sample x0=0
        lut_fill(8);
        begin_run();
        exp_v[0] = 0;   exp_v[1] = 100; exp_v[2] = 300;
        run_check("f8a2", 3, 2);
        end_run();

        // rounding of half-sample steps
        begin_run();
        din_v[0] = 0;   din_v[1] = 3;
`ifdef DBF_FINE_ROUND_EN
        exp_v[0] = 0;   exp_v[1] = 2;
`else
        exp_v[0] = 0;   exp_v[1] = 1;
`endif
        run_check("rnd_pos", 2, 1);
        end_run();
        begin_run();
        din_v[0] = 0;   din_v[1] = -3;
`ifdef DBF_FINE_ROUND_EN
        exp_v[0] = 0;   exp_v[1] = -1;
`else
        exp_v[0] = 0;   exp_v[1] = -2;
`endif
        run_check("rnd_neg", 2, 1);
        end_run();

        // abort: start drops two clocks after the first sample
        begin_run();
        apo_din   = 16'd1;
        din       = 14'd100;
        din_valid = 1'b1;
        tick();
        din       = 14'd200;
        tick();
        start     = 1'b0;
        din_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            check("abort_vld", dout_valid, 0);
        end
        check("abort_dout", dout, 0);

        // write with start rising, then in RUN: both blocked and flagged
        start    = 1'b1;
        lut_addr = 3'd0;
        lut_din  = 4'd0;
        lut_we   = 1'b1;
        tick();
        check("err_start", lut_wr_err, 1);
        lut_addr = 3'd1;
        tick();
        check("err_run", lut_wr_err, 1);
        lut_we = 1'b0;
        tick();
        check("err_clear", lut_wr_err, 0);
        din_v[0] = 0;   din_v[1] = 100; din_v[2] = 200;
        exp_v[0] = 0;   exp_v[1] = 50;  exp_v[2] = 150;
        run_check("lut_kept", 3, 1);

        // asynchronous reset mid-RUN with a held output and a pending error pulse
        lut_we = 1'b1;
        tick();
        check("pre_rst_err", lut_wr_err, 1);
        check("pre_rst_dout", $signed(dout), 150);
        din       = 14'd50;
        din_valid = 1'b1;
        rst_n     = 1'b0;
        #2;
        check("async_dout", dout, 0);
        check("async_vld", dout_valid, 0);
        check("async_err", lut_wr_err, 0);
        lut_we    = 1'b0;
        din_valid = 1'b0;
        start     = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        lut_write(0, 8);
        check("post_rst_idle", lut_wr_err, 0);

        // cnt saturates at the last LUT entry
        for (int k = 0; k < 2**ADDR_WD; k++) lut_write(k, k);
        begin_run();
        for (int n = 0; n < 12; n++) begin
            din_v[n] = 16 * n;
            exp_v[n] = (n == 0) ? 0 : 16 * (n - 1) + ((n < 7) ? n : 7);
        end
        run_check("sat", 12, 1);
        end_run();
        check("idle_dout", dout, 0);
        check("idle_vld", dout_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
